recv_session_ctrl: RTL and testbench

Session controller for the PAICORE receive path. It arms and disarms the receive chain on host command, and drives the transport-up control inputs (busy, done, receiving). It also supplies the padding stage's output-frame target, counts frames at both ends of the chain, and ends a session on a frame target, upstream completion, idle timeout or abort. It sits beside the receive datapath and is written by the host register block.

---
 rtl/recv_session_ctrl_pkg.sv | 15 +
 rtl/recv_session_ctrl_sat_counter.sv | 33 +++
 rtl/recv_session_ctrl.sv | 164 ++++++++++++++++
 tb/tb_recv_session_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recv_session_ctrl_pkg.sv
// Shared definitions for the PAICORE receive-session controller:
// session state encoding and default counter widths.
package recv_session_ctrl_pkg;

  localparam int FRAME_W_DEF = 32;
  localparam int TMO_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } recv_state_e;

endpackage

// File: rtl/recv_session_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/recv_session_ctrl.sv
// Receive-session controller: arms/disarms the receive chain, counts frames at
// both ends, and ends a session on frame target, rx_done, idle timeout or abort.
module recv_session_ctrl
  import recv_session_ctrl_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_areset,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] cfg_frame_num,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               snn_out_hsked,
  input  logic               read_hsked,
  input  logic               rx_done,
  output logic               o_rx_rcving,
  output logic               o_recv_busy,
  output logic               o_recv_done,
  output logic [FRAME_W-1:0] oFrameNumMax,
  output logic [FRAME_W-1:0] rcv_count,
  output logic [FRAME_W-1:0] out_count,
  output logic               sts_timeout,
  output logic               sts_abort,
  output recv_state_e        dbg_state
);

  // snn_out_hsked and read_hsked are single-cycle strobes: each high cycle
  // means exactly one frame was accepted (valid && ready) that cycle.

  recv_state_e        state_q, state_d;
  logic               rcving_q, rcving_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] frame_max_q, frame_max_d;
  logic [TMO_W-1:0]   tmo_limit_q, tmo_limit_d;
  logic               sts_timeout_q, sts_timeout_d;
  logic               sts_abort_q, sts_abort_d;

  logic [TMO_W-1:0]   idle_cnt;
  logic [FRAME_W:0]   rcv_sum, out_sum;
  logic [FRAME_W-1:0] drain_tgt;
  logic               active, any_hs, start_acc;
  logic               frame_hit, drain_hit, tmo_fire;
  logic               leave_recv, idle_clr, idle_inc;

  assign active    = (state_q == ST_RECV) || (state_q == ST_DRAIN);
  assign any_hs    = snn_out_hsked || read_hsked;
  assign start_acc = (state_q == ST_IDLE) && start && !abort;

  // Sums include this cycle's handshake so the exit cycle sees its own frame.
  assign rcv_sum   = {1'b0, rcv_count} + {{FRAME_W{1'b0}}, snn_out_hsked};
  assign out_sum   = {1'b0, out_count} + {{FRAME_W{1'b0}}, read_hsked};
  assign frame_hit = (frame_max_q != '0) && (rcv_sum >= {1'b0, frame_max_q});
  assign drain_tgt = (frame_max_q != '0) ? frame_max_q : rcv_count;
  assign drain_hit = out_sum >= {1'b0, drain_tgt};
  assign tmo_fire  = active && (tmo_limit_q != '0) && !any_hs &&
                     (idle_cnt == tmo_limit_q - TMO_W'(1));

  // The idle window restarts on entering DRAIN so the drain gets a full timeout.
  assign leave_recv = (state_q == ST_RECV) && (state_d != ST_RECV);
  assign idle_clr   = !active || any_hs || leave_recv;
  assign idle_inc   = active && !any_hs;

  sat_counter #(.W(FRAME_W)) u_rcv_cnt (
    .clk_i   (m_axis_aclk),
    .rst_i   (m_axis_areset),
    .clr_i   (start_acc),
    .inc_i   (active && snn_out_hsked),
    .count_o (rcv_count)
  );

  sat_counter #(.W(FRAME_W)) u_out_cnt (
    .clk_i   (m_axis_aclk),
    .rst_i   (m_axis_areset),
    .clr_i   (start_acc),
    .inc_i   (active && read_hsked),
    .count_o (out_count)
  );

  sat_counter #(.W(TMO_W)) u_idle_cnt (
    .clk_i   (m_axis_aclk),
    .rst_i   (m_axis_areset),
    .clr_i   (idle_clr),
    .inc_i   (idle_inc),
    .count_o (idle_cnt)
  );

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q       <= ST_IDLE;
      rcving_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_max_q   <= '0;
      tmo_limit_q   <= '0;
      sts_timeout_q <= 1'b0;
      sts_abort_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rcving_q      <= rcving_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_max_q   <= frame_max_d;
      tmo_limit_q   <= tmo_limit_d;
      sts_timeout_q <= sts_timeout_d;
      sts_abort_q   <= sts_abort_d;
    end
  end

  // Abort is checked first in every active state so it beats all other exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_RECV;
      ST_RECV: begin
        if (abort)                               state_d = ST_IDLE;
        else if (frame_hit || rx_done || tmo_fire) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                      state_d = ST_IDLE;
        else if (drain_hit || tmo_fire) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    rcving_d = (state_d == ST_RECV);
    busy_d   = (state_d == ST_RECV) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
  end

  always_comb begin
    frame_max_d   = frame_max_q;
    tmo_limit_d   = tmo_limit_q;
    sts_timeout_d = sts_timeout_q;
    sts_abort_d   = sts_abort_q;
    if (start_acc) begin
      frame_max_d   = cfg_frame_num;
      tmo_limit_d   = cfg_timeout;
      sts_timeout_d = 1'b0;
      sts_abort_d   = 1'b0;
    end else if (abort && (state_q != ST_IDLE)) begin
      sts_abort_d = 1'b1;
    end else if ((state_q == ST_RECV) && tmo_fire && !frame_hit && !rx_done) begin
      sts_timeout_d = 1'b1;
    end else if ((state_q == ST_DRAIN) && tmo_fire && !drain_hit) begin
      sts_timeout_d = 1'b1;
    end
  end

  assign o_rx_rcving  = rcving_q;
  assign o_recv_busy  = busy_q;
  assign o_recv_done  = done_q;
  assign oFrameNumMax = frame_max_q;
  assign sts_timeout  = sts_timeout_q;
  assign sts_abort    = sts_abort_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_recv_session_ctrl.sv
// Bench for recv_session_ctrl: directed session scenarios plus randomized
// traffic, every cycle scored against a behavioural session model.
module tb_recv_session_ctrl;
  import recv_session_ctrl_pkg::*;

  localparam int FW   = 4;
  localparam int TW   = 8;
  localparam int FMAX = (1 << FW) - 1;
  localparam int EW   = 2 + 3 + 3 * FW + 2;

  localparam int P_IDLE  = 0;
  localparam int P_RECV  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, start, abort, snn, rd, rxd;
  logic [FW-1:0] cfg_fn;
  logic [TW-1:0] cfg_to;
  logic o_rx_rcving, o_recv_busy, o_recv_done, sts_timeout, sts_abort;
  logic [FW-1:0] frame_max, rcv_count, out_count;
  recv_state_e dbg_state;

  always #5 clk = ~clk;

  recv_session_ctrl #(.FRAME_W(FW), .TMO_W(TW)) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .start         (start),
    .abort         (abort),
    .cfg_frame_num (cfg_fn),
    .cfg_timeout   (cfg_to),
    .snn_out_hsked (snn),
    .read_hsked    (rd),
    .rx_done       (rxd),
    .o_rx_rcving   (o_rx_rcving),
    .o_recv_busy   (o_recv_busy),
    .o_recv_done   (o_recv_done),
    .oFrameNumMax  (frame_max),
    .rcv_count     (rcv_count),
    .out_count     (out_count),
    .sts_timeout   (sts_timeout),
    .sts_abort     (sts_abort),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ph, m_max, m_tmo, m_rcv, m_out, m_streak;
  bit m_sto, m_sab;

  function automatic recv_state_e ph_enc(input int p);
    case (p)
      P_RECV:  return ST_RECV;
      P_DRAIN: return ST_DRAIN;
      P_DONE:  return ST_DONE;
      default: return ST_IDLE;
    endcase
  endfunction

  // m_streak is the length of the current run of silent active cycles.
  task automatic model_step();
    bit act, hs, to, hit, dhit;
    int tgt;
    if (rst) begin
      m_ph = P_IDLE; m_max = 0; m_tmo = 0; m_rcv = 0; m_out = 0;
      m_streak = 0; m_sto = 0; m_sab = 0;
    end else begin
      act  = (m_ph == P_RECV) || (m_ph == P_DRAIN);
      hs   = snn || rd;
      to   = act && (m_tmo != 0) && !hs && (m_streak + 1 == m_tmo);
      hit  = (m_max != 0) && (m_rcv + int'(snn) >= m_max);
      tgt  = (m_max != 0) ? m_max : m_rcv;
      dhit = (m_out + int'(rd) >= tgt);
      if (act) begin
        if (snn && m_rcv < FMAX) m_rcv++;
        if (rd && m_out < FMAX) m_out++;
        m_streak = hs ? 0 : m_streak + 1;
      end
      case (m_ph)
        P_IDLE: if (start && !abort) begin
          m_ph = P_RECV; m_max = int'(cfg_fn); m_tmo = int'(cfg_to);
          m_rcv = 0; m_out = 0; m_streak = 0; m_sto = 0; m_sab = 0;
        end
        P_RECV: begin
          if (abort) begin
            m_ph = P_IDLE; m_sab = 1;
          end else if (hit || rxd || to) begin
            m_ph = P_DRAIN; m_streak = 0;
            if (!hit && !rxd) m_sto = 1;
          end
        end
        P_DRAIN: begin
          if (abort) begin
            m_ph = P_IDLE; m_sab = 1;
          end else if (dhit) begin
            m_ph = P_DONE;
          end else if (to) begin
            m_ph = P_DONE; m_sto = 1;
          end
        end
        default: begin
          if (abort) m_sab = 1;
          m_ph = P_IDLE;
        end
      endcase
    end
    exp_q.push_back({ph_enc(m_ph), (m_ph == P_RECV), (m_ph == P_RECV) || (m_ph == P_DRAIN),
                     (m_ph == P_DONE), FW'(m_max), FW'(m_rcv), FW'(m_out), m_sto, m_sab});
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    chk("state",       dbg_state,   e[EW-1:EW-2]);
    chk("rx_rcving",   o_rx_rcving, e[EW-3]);
    chk("recv_busy",   o_recv_busy, e[EW-4]);
    chk("recv_done",   o_recv_done, e[EW-5]);
    chk("frame_max",   frame_max,   e[EW-6 -: FW]);
    chk("rcv_count",   rcv_count,   e[EW-6-FW -: FW]);
    chk("out_count",   out_count,   e[EW-6-2*FW -: FW]);
    chk("sts_timeout", sts_timeout, e[1]);
    chk("sts_abort",   sts_abort,   e[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit st, input bit s, input bit r, input bit d, input bit a);
    start = st; snn = s; rd = r; rxd = d; abort = a;
    tick();
    start = 0; snn = 0; rd = 0; rxd = 0; abort = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    int dens;
    rst = 1; start = 0; abort = 0; snn = 0; rd = 0; rxd = 0;
    cfg_fn = '0; cfg_to = '0;
    tick(); tick();
    chk("rst_busy", o_recv_busy, 0);
    chk("rst_rcv_count", rcv_count, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 0;

    // frame target 4, no timeout
    cfg_fn = 4; cfg_to = 0;
    drive(1, 0, 0, 0, 0);
    chk("s1_rcving", o_rx_rcving, 1);
    chk("s1_busy", o_recv_busy, 1);
    repeat (3) drive(0, 1, 0, 0, 0);
    chk("s1_still_recv", dbg_state, ST_RECV);
    drive(0, 1, 0, 0, 0);
    chk("s1_drain", dbg_state, ST_DRAIN);
    chk("s1_rcv4", rcv_count, 4);
    repeat (3) drive(0, 0, 1, 0, 0);
    chk("s1_no_done", o_recv_done, 0);
    drive(0, 0, 1, 0, 0);
    chk("s1_done", o_recv_done, 1);
    chk("s1_busy_low", o_recv_busy, 0);
    chk("s1_out4", out_count, 4);
    tick();
    chk("s1_done_pulse_end", o_recv_done, 0);

    // unbounded session ended by rx_done
    cfg_fn = 0;
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    chk("s2_no_target", dbg_state, ST_RECV);
    drive(0, 0, 0, 1, 0);
    chk("s2_drain", dbg_state, ST_DRAIN);
    chk("s2_fmax0", frame_max, 0);
    repeat (2) drive(0, 0, 1, 0, 0);
    chk("s2_no_done", o_recv_done, 0);
    drive(0, 0, 1, 0, 0);
    chk("s2_done", o_recv_done, 1);
    tick();

    // idle timeout of 10 cycles
    cfg_fn = 0; cfg_to = 10;
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0);
    repeat (9) tick();
    chk("s3_recv_at_9", dbg_state, ST_RECV);
    tick();
    chk("s3_drain_at_10", dbg_state, ST_DRAIN);
    chk("s3_sts_to", sts_timeout, 1);
    pulses = 0;
    repeat (12) begin
      tick();
      if (o_recv_done) pulses++;
    end
    chk("s3_one_pulse", pulses, 1);
    chk("s3_sts_to_end", sts_timeout, 1);
    chk("s3_idle", dbg_state, ST_IDLE);
    cfg_to = 0;

    // abort in DRAIN together with the final read
    cfg_fn = 2;
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1);
    chk("s4_idle", dbg_state, ST_IDLE);
    chk("s4_no_done", o_recv_done, 0);
    chk("s4_sts_abort", sts_abort, 1);
    chk("s4_out2", out_count, 2);
    chk("s4_busy", o_recv_busy, 0);
    tick();
    chk("s4_still_no_done", o_recv_done, 0);

    // start during RECV ignored; start+abort in IDLE stays IDLE
    cfg_fn = 3;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("s5_recv_kept", dbg_state, ST_RECV);
    chk("s5_rcv_kept", rcv_count, 1);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    chk("s5_start_abort_idle", dbg_state, ST_IDLE);
    chk("s5_start_abort_busy", o_recv_busy, 0);

    // reset mid-RECV
    cfg_fn = 0;
    drive(1, 0, 0, 0, 0);
    repeat (7) drive(0, 1, 0, 0, 0);
    chk("s6_rcv7", rcv_count, 7);
    rst = 1;
    tick();
    rst = 0;
    chk("s6_rcv0", rcv_count, 0);
    chk("s6_busy0", o_recv_busy, 0);
    chk("s6_rcving0", o_rx_rcving, 0);
    chk("s6_done0", o_recv_done, 0);
    cfg_fn = 1;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("s6_drain", dbg_state, ST_DRAIN);
    drive(0, 0, 1, 0, 0);
    chk("s6_done", o_recv_done, 1);
    tick();

    // counter saturation in an unbounded session
    cfg_fn = 0;
    drive(1, 0, 0, 0, 0);
    repeat (20) drive(0, 1, 0, 0, 0);
    chk("s7_sat", rcv_count, FMAX);
    drive(0, 0, 0, 1, 0);
    repeat (FMAX - 1) drive(0, 0, 1, 0, 0);
    chk("s7_no_done", o_recv_done, 0);
    drive(0, 0, 1, 0, 0);
    chk("s7_done", o_recv_done, 1);
    tick();

    // randomized traffic
    for (int blk = 0; blk < 40; blk++) begin
      dens   = $urandom_range(5, 70);
      cfg_fn = ($urandom_range(0, 7) == 7) ? FW'(FMAX) : FW'($urandom_range(0, 6));
      cfg_to = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 8));
      for (int c = 0; c < 80; c++) begin
        start = ($urandom_range(0, 99) < 15);
        snn   = ($urandom_range(0, 99) < dens);
        rd    = ($urandom_range(0, 99) < dens);
        rxd   = ($urandom_range(0, 99) < 4);
        abort = ($urandom_range(0, 99) < 2);
        rst   = ($urandom_range(0, 999) < 3);
        if ($urandom_range(0, 9) == 0) cfg_fn = FW'($urandom_range(0, 6));
        tick();
      end
    end
    rst = 0; start = 0; abort = 0; snn = 0; rd = 0; rxd = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
